// File: rtl/armaria_decode_pkg.sv
// Shared decode definitions: instruction-ID constants, stage FSM states and the
// Thumb-style instruction-to-ID decode used by instruction_decode_stage.
package armaria_decode_pkg;

  localparam int unsigned ID_W    = 7;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 2;

  localparam logic [ID_W-1:0] ID_RESET = 7'd100;
  localparam logic [ID_W-1:0] ID_SWI   = 7'd72;
  localparam logic [ID_W-1:0] ID_HALT  = 7'd75;
  localparam logic [ID_W-1:0] ID_UNDEF = 7'd0;

  // BKPT #0 is the halt request; BKPT with any other immediate is undefined here
  localparam logic [INSTR_W-1:0] INSTR_HALT = 16'hBE00;

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    RUN     = 2'd1,
    HALT    = 2'd2
  } state_t;

  function automatic logic is_undef(input logic [INSTR_W-1:0] instr);
    return (instr != INSTR_HALT) &&
           ((instr[15:8] == 8'hDE) || (instr[15:8] == 8'hBE) || (instr[15:11] == 5'b11101));
  endfunction

  // Ordinary formats map to their 5-bit major opcode plus one (IDs 1..32)
  function automatic logic [ID_W-1:0] decode_id(input logic [INSTR_W-1:0] instr);
    logic [ID_W-1:0] id;
    id = ID_W'(instr[15:11]) + ID_W'(1);
    if (instr == INSTR_HALT)        id = ID_HALT;
    else if (instr[15:8] == 8'hDF)  id = ID_SWI;
    else if (is_undef(instr))       id = ID_UNDEF;
    return id;
  endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and control-core-side handshake bundle of the instruction decode stage.
interface instruction_decode_stage_if;
  import armaria_decode_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               id_valid;
  logic [ID_W-1:0]    id;
  logic               id_ready;
  logic               resume;
  logic               halted;
  logic               illegal;

  modport master (
    output instr_valid, instr, id_ready, resume,
    input  instr_ready, id_valid, id, halted, illegal
  );

  modport slave (
    input  instr_valid, instr, id_ready, resume,
    output instr_ready, id_valid, id, halted, illegal
  );
endinterface

// File: rtl/id_fifo2.sv
// Two-entry ID buffer with 1-bit wrapping pointers and an occupancy count.
module id_fifo2
  import armaria_decode_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ID_W-1:0]  din,
  input  logic             pop,
  output logic [ID_W-1:0]  dout,
  output logic [CNT_W-1:0] count
);

  logic [ID_W-1:0] mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != CNT_W'(2));
  assign do_pop  = pop  && (count != CNT_W'(0));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= CNT_W'(0);
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: decodes fetched words into control-core IDs through a
// 2-entry FIFO, with reset-ID sequence and halt/resume. DECODE_ILLEGAL_TRAP_EN maps undefined words to SWI.
module instruction_decode_stage
  import armaria_decode_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  instruction_decode_stage_if.slave  bus
);

  state_t           state, state_nx;
  logic [1:0]       rst_cnt, rst_cnt_nx;
  logic             halt_pending, halt_pending_nx;
  logic [CNT_W-1:0] fifo_count;
  logic [ID_W-1:0]  fifo_head;
  logic [ID_W-1:0]  dec_id;
  logic [ID_W-1:0]  push_id;
  logic             dec_undef;
  logic             accept;
  logic             fifo_pop;

  assign dec_id    = decode_id(bus.instr);
  assign dec_undef = is_undef(bus.instr);
  assign accept    = bus.instr_valid && bus.instr_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign push_id = dec_undef ? ID_SWI : dec_id;
`else
  assign push_id = dec_undef ? ID_UNDEF : dec_id;
`endif

  id_fifo2 u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (accept),
    .din   (push_id),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RST_SEQ;
      rst_cnt      <= 2'd2;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_nx;
      rst_cnt      <= rst_cnt_nx;
      halt_pending <= halt_pending_nx;
    end
  end

  // Handshake outputs are forced idle while reset is held
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id          = fifo_head;
    bus.halted      = 1'b0;
    if (!reset) begin
      case (state)
        RST_SEQ: begin
          bus.id_valid = 1'b1;
          bus.id       = ID_RESET;
        end
        RUN: begin
          bus.id_valid    = (fifo_count != CNT_W'(0));
          bus.instr_ready = (fifo_count < CNT_W'(2)) && !halt_pending;
        end
        HALT:    bus.halted = 1'b1;
        default: bus.id_valid = 1'b0;
      endcase
    end
    bus.illegal = accept && dec_undef;
  end

  always_comb begin
    state_nx        = state;
    rst_cnt_nx      = rst_cnt;
    halt_pending_nx = halt_pending;
    fifo_pop        = 1'b0;
    case (state)
      RST_SEQ: begin
        if (bus.id_ready) begin
          rst_cnt_nx = rst_cnt - 2'd1;
          if (rst_cnt == 2'd1) state_nx = RUN;
        end
      end
      RUN: begin
        if (accept && (dec_id == ID_HALT)) halt_pending_nx = 1'b1;
        if (bus.id_valid && bus.id_ready) begin
          fifo_pop = 1'b1;
          // Nothing is accepted behind a halt, so the FIFO drains empty here
          if (fifo_head == ID_HALT) begin
            state_nx        = HALT;
            halt_pending_nx = 1'b0;
          end
        end
      end
      HALT: begin
        if (bus.resume) state_nx = RUN;
      end
      default: state_nx = RST_SEQ;
    endcase
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed scenarios then randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_instruction_decode_stage;
  import armaria_decode_pkg::*;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  instruction_decode_stage_if bus();

  instruction_decode_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  int q[$];
  int mode    = M_BOOT;
  int rs_left = 2;
  bit hp      = 1'b0;
  int undef_push_id;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode; -1 marks an undefined encoding
  function automatic int ref_decode(input int w);
    int op;
    int fmt;
    op  = w / 256;
    fmt = w / 2048;
    if (w == 48640) return 75;
    if (op == 223) return 72;
    if (op == 222 || op == 190 || fmt == 29) return -1;
    return fmt + 1;
  endfunction

  function automatic int pick_instr();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0:       return 48640;
      1:       return 57088 + $urandom_range(0, 255);
      2:       return 56832 + $urandom_range(0, 255);
      3:       return 59392 + $urandom_range(0, 2047);
      4:       return 48640 + $urandom_range(1, 255);
      default: return $urandom_range(0, 65535);
    endcase
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model
  task automatic cycle(input bit rst, input bit iv, input int iw, input bit ir, input bit rs);
    int e_ready, e_valid, e_id, e_halt, e_ill, d, head;
    reset           = rst;
    bus.instr_valid = iv;
    bus.instr       = 16'(iw);
    bus.id_ready    = ir;
    bus.resume      = rs;
    #1;
    e_ready = 0; e_valid = 0; e_id = 0; e_halt = 0;
    d = ref_decode(iw);
    if (!rst) begin
      case (mode)
        M_BOOT: begin e_valid = 1; e_id = 100; end
        M_RUN: begin
          if (q.size() > 0) begin e_valid = 1; e_id = q[0]; end
          if (q.size() < 2 && !hp) e_ready = 1;
        end
        default: e_halt = 1;
      endcase
    end
    e_ill = (e_ready == 1 && iv && d < 0) ? 1 : 0;
    check("instr_ready", int'(bus.instr_ready), e_ready);
    check("id_valid",    int'(bus.id_valid),    e_valid);
    check("halted",      int'(bus.halted),      e_halt);
    check("illegal",     int'(bus.illegal),     e_ill);
    if (e_valid == 1) check("id", int'(bus.id), e_id);
    @(posedge clock);
    if (rst) begin
      q.delete();
      mode = M_BOOT; rs_left = 2; hp = 1'b0;
    end else begin
      case (mode)
        M_BOOT: if (ir) begin
          rs_left--;
          if (rs_left == 0) mode = M_RUN;
        end
        M_RUN: begin
          if (e_valid == 1 && ir) begin
            head = q.pop_front();
            if (head == 75) begin mode = M_HALT; hp = 1'b0; end
          end
          if (e_ready == 1 && iv) begin
            q.push_back(d < 0 ? undef_push_id : d);
            if (d == 75) hp = 1'b1;
          end
        end
        default: if (rs) mode = M_RUN;
      endcase
    end
    @(negedge clock);
  endtask

  initial begin
`ifdef DECODE_ILLEGAL_TRAP_EN
    undef_push_id = 72;
`else
    undef_push_id = 0;
`endif
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.id_ready    = 1'b0;
    bus.resume      = 1'b0;

    repeat (3) cycle(1, 1, 16'h1234, 1, 0);
    // reset ID sequence, then first accept in the third cycle
    repeat (3) cycle(0, 1, 16'h1234, 1, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);
    // back-to-back fill with core stalled, then a single pop
    cycle(0, 1, 16'h0800, 0, 0);
    cycle(0, 1, 16'h1000, 0, 0);
    cycle(0, 1, 16'h1800, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    // simultaneous push and pop at count 1
    cycle(0, 1, 16'h2000, 0, 0);
    cycle(0, 1, 16'h2800, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    // halt followed by more offered words, drain into HALT, resume
    cycle(0, 1, 16'hBE00, 0, 0);
    repeat (2) cycle(0, 1, 16'h3000, 0, 0);
    repeat (3) cycle(0, 1, 16'h3000, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 16'h3800, 1, 0);
    // undefined encodings and SWI pass-through
    cycle(0, 1, 16'hDE12, 0, 0);
    cycle(0, 1, 16'hDF05, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 16'hE9AB, 1, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);
    // reset with a full FIFO and a pending halt
    cycle(0, 1, 16'h4000, 0, 0);
    cycle(0, 1, 16'hBE00, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);

    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), pick_instr(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; clock and reset are the first two ports.
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instr_valid  in  1  fetch offers an instruction word.
REQ-005 instr  in  16  Thumb-style instruction word.
REQ-006 instr_ready  out  1  stage accepts instr this cycle.
REQ-007 id_valid  out  1  head ID available to the control core.
REQ-008 id  out  7  decoded instruction ID, control-core encoding.
REQ-009 id_ready  in  1  control core consumes the head ID this cycle.
REQ-010 resume  in  1  single-cycle pulse; leaves HALT.
REQ-011 halted  out  1  high while in HALT.
REQ-012 illegal  out  1  one-cycle pulse when an undefined encoding is accepted.

Function
REQ-013 Transfer in when instr_valid && instr_ready; transfer out when id_valid && id_ready.
REQ-014 Decode is combinational; the ID is written into a 2-entry FIFO in the accept cycle, so id_valid rises no earlier than the next cycle (1-cycle latency).
REQ-015 instr_ready = (state==RUN) && (count<2) && !halt_pending; it has no combinational dependence on id_ready.
REQ-016 id/id_valid come from the FIFO head, except in RST_SEQ; a push and a pop in the same cycle leave count unchanged.
REQ-017 Undefined encodings decode to ID 0; illegal pulses in the accept cycle.
REQ-018 FSM states: RST_SEQ, RUN, HALT.
REQ-019 RST_SEQ: id_valid=1, id=100, instr_ready=0; a 2-bit counter preloaded to 2 decrements per id_ready; move to RUN on the cycle the second ID 100 is consumed.
REQ-020 RUN: when ID 75 is pushed, set halt_pending; instr_ready stays 0 afterwards.
REQ-021 RUN->HALT on the cycle ID 75 is popped; clear halt_pending. FIFO is then empty because nothing was accepted after 75.
REQ-022 HALT: id_valid=0, instr_ready=0, halted=1; resume -> RUN next cycle; resume outside HALT is ignored.
REQ-023 FIFO pointers are 1 bit and wrap modulo 2; count is 0..2; no push at count 2 and no pop at count 0.
REQ-024 ID 72 (SWI) passes through like any other ID; the stage does not stall on it.

Reset
REQ-025 While reset=1: state=RST_SEQ, counter=2, FIFO empty, halt_pending=0, illegal=0, halted=0, instr_ready=0, id_valid=0.
REQ-026 On the first cycle after reset=0: id_valid=1, id=100.
REQ-027 Reset asserted mid-operation discards FIFO contents and any pending halt the same cycle.

Configuration
REQ-028 Macro DECODE_ILLEGAL_TRAP_EN: when defined, an undefined encoding is pushed as ID 72 (SWI) and illegal still pulses.
REQ-029 Without DECODE_ILLEGAL_TRAP_EN, an undefined encoding is pushed as ID 0 and illegal still pulses.

Structure
REQ-030 Shared package armaria_decode_pkg SHALL hold ID constants (ID_RESET=100, ID_SWI=72, ID_HALT=75, ID_UNDEF=0), the state enum and the instr-to-ID decode function.
REQ-031 Sub-module id_fifo2 (2-entry, 7-bit, count output) SHALL hold the buffer; FSM and decode stay in the top module.

Verification
REQ-032 Reset release with id_ready=1 -> id=100 for exactly 2 cycles, then instr_ready=1 in the third cycle.
REQ-033 Back-to-back instrs with id_ready=0 -> 2 accepted, instr_ready=0 with count=2; id_ready=1 for 1 cycle -> oldest ID popped, order preserved.
REQ-034 Push and pop in the same cycle at count=1 -> count stays 1, no ID lost or duplicated.
REQ-035 HALT instr followed by valid instrs -> no accept after HALT, halted=1 after ID 75 is popped; resume pulse -> instr_ready=1 next cycle.
REQ-036 Undefined encoding -> illegal=1 for one cycle; id=72 with DECODE_ILLEGAL_TRAP_EN, id=0 without.
REQ-037 reset asserted with count=2 and halt_pending=1 -> next cycle FIFO empty, RST_SEQ, id=100.
